// File: rtl/motor_driver_if.sv
// Command and status bundle between robot_fsm (master) and motor_driver (slave).
// The command is level-based: motor_state/overwrite are sampled every cycle, with no valid/ready handshake.
interface motor_driver_if #(
  parameter int PWM_BITS = 8
);
  logic [4:0]          motor_state;
  logic                overwrite;
  logic                pwm_l;
  logic                pwm_r;
  logic                dir_l;
  logic                dir_r;
  logic                enable;
  logic                busy;
  logic                cmd_err;
  // Debug view of each wheel channel: current duty and whether it is in dead time.
  logic [PWM_BITS-1:0] duty_l;
  logic [PWM_BITS-1:0] duty_r;
  logic                dead_l;
  logic                dead_r;

  modport master (
    output motor_state, overwrite,
    input  pwm_l, pwm_r, dir_l, dir_r, enable, busy, cmd_err,
    input  duty_l, duty_r, dead_l, dead_r
  );

  modport slave (
    input  motor_state, overwrite,
    output pwm_l, pwm_r, dir_l, dir_r, enable, busy, cmd_err,
    output duty_l, duty_r, dead_l, dead_r
  );
endinterface

// File: rtl/motor_driver.sv
// Two-wheel H-bridge driver: decodes robot_fsm commands, ramps each wheel's duty,
// inserts dead time before direction reversal and generates one PWM per wheel.
module motor_driver #(
  parameter int PWM_BITS  = 8,
  parameter int DUTY_FWD  = 192,
  parameter int DUTY_TURN = 96,
  parameter int RAMP_DIV  = 50000,
  parameter int RAMP_STEP = 4,
  parameter int DEADTIME  = 25000
) (
  input logic           CLOCK_50,
  input logic           reset,
  motor_driver_if.slave bus
);

  typedef logic [PWM_BITS-1:0] duty_t;
  typedef enum logic {TRACK = 1'b0, DEAD = 1'b1} ch_state_t;

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [RW-1:0]     RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]     DEAD_LAST = DW'(DEADTIME - 1);
  localparam duty_t             FWD       = duty_t'(DUTY_FWD);
  localparam duty_t             TURN      = duty_t'(DUTY_TURN);
  localparam logic [PWM_BITS:0] STEP      = (PWM_BITS + 1)'(RAMP_STEP);

  logic [4:0]    ms_q;
  logic          ow_q;
  logic [RW-1:0] ramp_cnt;
  logic          tick;
  duty_t         pwm_cnt;
  logic          enable_q;
  logic          err_q;

  logic          tgt_dir  [2];
  duty_t         tgt_duty [2];
  logic          cmd_bad;

  ch_state_t     st       [2];
  logic          dir_q    [2];
  duty_t         duty_q   [2];
  logic [DW-1:0] dead_cnt [2];
  logic          pwm_q    [2];

  // Move cur toward tgt by at most STEP; the extra bit keeps the gap from wrapping.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    logic [PWM_BITS:0] gap;
    duty_t             res;
    if (cur < tgt) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      res = (gap > STEP) ? duty_t'({1'b0, cur} + STEP) : tgt;
    end else begin
      gap = {1'b0, cur} - {1'b0, tgt};
      res = (gap > STEP) ? duty_t'({1'b0, cur} - STEP) : tgt;
    end
    return res;
  endfunction

  assign tick = (ramp_cnt == RAMP_LAST);

  always_comb begin
    tgt_dir[0]  = 1'b0;
    tgt_dir[1]  = 1'b0;
    tgt_duty[0] = '0;
    tgt_duty[1] = '0;
    cmd_bad     = 1'b0;
    case (ms_q)
      5'b00001: ;
      5'b00010: begin
        tgt_duty[0] = FWD;
        tgt_duty[1] = FWD;
      end
      5'b00100: begin
        tgt_dir[0]  = 1'b1;
        tgt_duty[0] = TURN;
        tgt_duty[1] = TURN;
      end
      5'b01000: begin
        tgt_dir[1]  = 1'b1;
        tgt_duty[0] = TURN;
        tgt_duty[1] = TURN;
      end
      5'b10000: begin
        tgt_dir[0]  = 1'b1;
        tgt_dir[1]  = 1'b1;
        tgt_duty[0] = FWD;
        tgt_duty[1] = FWD;
      end
      default: cmd_bad = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // STOP rather than zero so the idle command register does not flag an error.
      ms_q     <= 5'b00001;
      ow_q     <= 1'b0;
      ramp_cnt <= '0;
      pwm_cnt  <= '0;
      enable_q <= 1'b0;
      err_q    <= 1'b0;
      for (int w = 0; w < 2; w++) begin
        st[w]       <= TRACK;
        dir_q[w]    <= 1'b0;
        duty_q[w]   <= '0;
        dead_cnt[w] <= '0;
        pwm_q[w]    <= 1'b0;
      end
    end else begin
      ms_q     <= bus.motor_state;
      ow_q     <= bus.overwrite;
      ramp_cnt <= tick ? '0 : ramp_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      enable_q <= ~ow_q;
      if (cmd_bad) err_q <= 1'b1;
      for (int w = 0; w < 2; w++) begin
        pwm_q[w] <= ~ow_q & (pwm_cnt < duty_q[w]);
        if (ow_q) begin
          duty_q[w]   <= '0;
          st[w]       <= DEAD;
          dead_cnt[w] <= '0;
        end else begin
          case (st[w])
            TRACK: begin
              if (tgt_dir[w] == dir_q[w]) begin
                if (tick) duty_q[w] <= step_toward(duty_q[w], tgt_duty[w]);
              end else if (duty_q[w] == '0) begin
                st[w]       <= DEAD;
                dead_cnt[w] <= '0;
              end else if (tick) begin
                duty_q[w] <= step_toward(duty_q[w], '0);
              end
            end
            DEAD: begin
              duty_q[w] <= '0;
              // Direction is taken from whatever target is current at exit.
              if (dead_cnt[w] == DEAD_LAST) begin
                dir_q[w] <= tgt_dir[w];
                st[w]    <= TRACK;
              end else begin
                dead_cnt[w] <= dead_cnt[w] + 1'b1;
              end
            end
            default: st[w] <= TRACK;
          endcase
        end
      end
    end
  end

  assign bus.pwm_l   = pwm_q[0];
  assign bus.pwm_r   = pwm_q[1];
  assign bus.dir_l   = dir_q[0];
  assign bus.dir_r   = dir_q[1];
  assign bus.enable  = enable_q;
  assign bus.cmd_err = err_q;
  assign bus.duty_l  = duty_q[0];
  assign bus.duty_r  = duty_q[1];
  assign bus.dead_l  = (st[0] == DEAD);
  assign bus.dead_r  = (st[1] == DEAD);
  assign bus.busy    = (st[0] == DEAD) | (st[1] == DEAD) |
                       (duty_q[0] != tgt_duty[0]) | (duty_q[1] != tgt_duty[1]);

endmodule

// File: tb/tb_motor_driver.sv
// Bench for motor_driver: decode vector table, hand-written corner sequences and
// randomized commands, all checked every cycle against a behavioural wheel model.
module tb_motor_driver;
  localparam int PWM_BITS  = 8;
  localparam int DUTY_FWD  = 128;
  localparam int DUTY_TURN = 64;
  localparam int RAMP_DIV  = 4;
  localparam int RAMP_STEP = 16;
  localparam int DEADTIME  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motor_driver_if #(.PWM_BITS(PWM_BITS)) bif ();

  motor_driver #(
    .PWM_BITS(PWM_BITS), .DUTY_FWD(DUTY_FWD), .DUTY_TURN(DUTY_TURN),
    .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  int         m_phase;
  logic [4:0] m_ms;
  logic       m_ow;
  logic       m_en;
  logic       m_err;
  int         m_duty [2];
  logic       m_dir  [2];
  int         m_dead [2];
  logic       m_pwm  [2];

  function automatic void decode(input logic [4:0] ms, output logic dl, output logic dr,
                                 output int tl, output int tr, output logic bad);
    dl = 1'b0; dr = 1'b0; tl = 0; tr = 0; bad = 1'b0;
    case (ms)
      5'b00001: ;
      5'b00010: begin tl = DUTY_FWD; tr = DUTY_FWD; end
      5'b00100: begin dl = 1'b1; tl = DUTY_TURN; tr = DUTY_TURN; end
      5'b01000: begin dr = 1'b1; tl = DUTY_TURN; tr = DUTY_TURN; end
      5'b10000: begin dl = 1'b1; dr = 1'b1; tl = DUTY_FWD; tr = DUTY_FWD; end
      default:  bad = 1'b1;
    endcase
  endfunction

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return (cur + RAMP_STEP > tgt) ? tgt : cur + RAMP_STEP;
    else           return (cur - RAMP_STEP < tgt) ? tgt : cur - RAMP_STEP;
  endfunction

  task automatic model_edge(input logic r, input logic [4:0] ms, input logic ow);
    logic td [2];
    int   tt [2];
    logic bad;
    bit   tick;
    if (r) begin
      m_phase = 0; m_ms = 5'b00001; m_ow = 1'b0; m_en = 1'b0; m_err = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_duty[w] = 0; m_dir[w] = 1'b0; m_dead[w] = 0; m_pwm[w] = 1'b0;
      end
    end else begin
      decode(m_ms, td[0], td[1], tt[0], tt[1], bad);
      tick = ((m_phase % RAMP_DIV) == RAMP_DIV - 1);
      for (int w = 0; w < 2; w++) m_pwm[w] = !m_ow && ((m_phase % 256) < m_duty[w]);
      m_en = !m_ow;
      if (bad) m_err = 1'b1;
      for (int w = 0; w < 2; w++) begin
        if (m_ow) begin
          m_duty[w] = 0;
          m_dead[w] = DEADTIME;
        end else if (m_dead[w] > 0) begin
          m_duty[w] = 0;
          if (m_dead[w] == 1) begin
            m_dir[w]  = td[w];
            m_dead[w] = 0;
          end else begin
            m_dead[w] = m_dead[w] - 1;
          end
        end else if (td[w] == m_dir[w]) begin
          if (tick) m_duty[w] = toward(m_duty[w], tt[w]);
        end else if (m_duty[w] == 0) begin
          m_dead[w] = DEADTIME;
        end else if (tick) begin
          m_duty[w] = toward(m_duty[w], 0);
        end
      end
      m_ms = ms;
      m_ow = ow;
      m_phase++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic dl, dr, bad, busy;
    int   tl, tr;
    logic [24:0] exp_v, act_v;
    @(posedge clk);
    model_edge(rst, bif.motor_state, bif.overwrite);
    #1;
    decode(m_ms, dl, dr, tl, tr, bad);
    busy  = (m_dead[0] > 0) || (m_dead[1] > 0) || (m_duty[0] != tl) || (m_duty[1] != tr);
    exp_v = {m_pwm[0], m_pwm[1], m_dir[0], m_dir[1], m_en, busy, m_err,
             8'(m_duty[0]), 8'(m_duty[1]), m_dead[0] > 0, m_dead[1] > 0};
    act_v = {bif.pwm_l, bif.pwm_r, bif.dir_l, bif.dir_r, bif.enable, bif.busy, bif.cmd_err,
             bif.duty_l, bif.duty_r, bif.dead_l, bif.dead_r};
    check("model", 32'(act_v), 32'(exp_v));
  endtask

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.motor_state = 5'b00001;
    bif.overwrite   = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  task automatic wait_duty(input int w, input int val, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if (((w == 0) ? bif.duty_l : bif.duty_r) == 8'(val)) hit = 1'b1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  task automatic wait_dead(input int w, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if (((w == 0) ? bif.dead_l : bif.dead_r) == 1'b1) hit = 1'b1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [4:0] ms;
    logic       dl;
    logic       dr;
    int         tl;
    int         tr;
    logic       err;
  } vec_t;
  vec_t vt [8];

  initial begin
    int  cnt;
    bit  flag_a;
    bit  flag_b;
    logic [4:0] ms;

    bif.motor_state = 5'b00001;
    bif.overwrite   = 1'b0;
    vt[0] = '{5'b00001, 1'b0, 1'b0, 0,         0,         1'b0};
    vt[1] = '{5'b00010, 1'b0, 1'b0, DUTY_FWD,  DUTY_FWD,  1'b0};
    vt[2] = '{5'b00100, 1'b1, 1'b0, DUTY_TURN, DUTY_TURN, 1'b0};
    vt[3] = '{5'b01000, 1'b0, 1'b1, DUTY_TURN, DUTY_TURN, 1'b0};
    vt[4] = '{5'b10000, 1'b1, 1'b1, DUTY_FWD,  DUTY_FWD,  1'b0};
    vt[5] = '{5'b00011, 1'b0, 1'b0, 0,         0,         1'b1};
    vt[6] = '{5'b00000, 1'b0, 1'b0, 0,         0,         1'b1};
    vt[7] = '{5'b11111, 1'b0, 1'b0, 0,         0,         1'b1};

    do_reset();
    check("reset_state", 32'({bif.pwm_l, bif.pwm_r, bif.dir_l, bif.dir_r, bif.enable,
                              bif.busy, bif.cmd_err, bif.duty_l, bif.duty_r}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      bif.motor_state = vt[i].ms;
      run(80);
      check($sformatf("vec%0d", i),
            32'({bif.dir_l, bif.dir_r, bif.duty_l, bif.duty_r, bif.cmd_err, bif.busy}),
            32'({vt[i].dl, vt[i].dr, 8'(vt[i].tl), 8'(vt[i].tr), vt[i].err, 1'b0}));
    end

    // Forward ramp from reset, then PWM duty over one full period.
    do_reset();
    bif.motor_state = 5'b00010;
    wait_duty(0, DUTY_FWD, 200, "fwd_reach");
    check("fwd_busy_dir", 32'({bif.busy, bif.dir_l, bif.dir_r}), 32'd0);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      cnt += int'(bif.pwm_l);
    end
    check("fwd_pwm_high", 32'(cnt), 32'(DUTY_FWD));

    // FORWARD -> LEFT: left reverses through dead time, right only slows.
    bif.motor_state = 5'b00100;
    cnt = 0; flag_a = 1'b0; flag_b = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (bif.dead_l) begin
        cnt++;
        if (bif.dir_l) flag_a = 1'b1;
      end
      if (bif.dir_r) flag_b = 1'b1;
    end
    check("left_dead_len", 32'(cnt), 32'(DEADTIME));
    check("left_dir_in_dead", 32'(flag_a), 32'd0);
    check("left_dir_r", 32'(flag_b), 32'd0);
    check("left_final", 32'({bif.dir_l, bif.duty_l, bif.duty_r}), 32'({1'b1, 8'd64, 8'd64}));

    // Overwrite pulse of 20 cycles at steady FORWARD.
    do_reset();
    bif.motor_state = 5'b00010;
    run(60);
    bif.overwrite = 1'b1;
    run(2);
    check("ow_off", 32'({bif.pwm_l, bif.pwm_r, bif.enable, bif.duty_l, bif.duty_r}), 32'd0);
    run(18);
    bif.overwrite = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 1) check("ow_enable", 32'(bif.enable), 32'd1);
      cnt += int'(bif.dead_l);
    end
    check("ow_dead_len", 32'(cnt), 32'(DEADTIME));
    wait_duty(0, DUTY_FWD, 100, "ow_reramp");

    // Illegal command is sticky until reset.
    do_reset();
    bif.motor_state = 5'b00010;
    run(60);
    bif.motor_state = 5'b00011;
    run(60);
    check("err_stop", 32'({bif.duty_l, bif.duty_r, bif.cmd_err}), 32'd1);
    bif.motor_state = 5'b00010;
    run(60);
    check("err_sticky", 32'({bif.cmd_err, bif.duty_l}), 32'({1'b1, 8'(DUTY_FWD)}));
    do_reset();
    check("err_cleared", 32'(bif.cmd_err), 32'd0);

    // Reset while a wheel is in dead time.
    bif.motor_state = 5'b00010;
    run(60);
    bif.motor_state = 5'b10000;
    wait_dead(0, 100, "rst_dead_reach");
    run(3);
    rst = 1'b1;
    bif.motor_state = 5'b00010;
    step();
    check("rst_mid_dead", 32'({bif.pwm_l, bif.pwm_r, bif.dir_l, bif.dir_r, bif.enable, bif.busy,
                               bif.cmd_err, bif.dead_l, bif.dead_r, bif.duty_l, bif.duty_r}), 32'd0);
    rst = 1'b0;
    wait_duty(0, DUTY_FWD, 100, "rst_reramp");

    // Target flips back to FORWARD just after left enters dead time.
    run(20);
    bif.motor_state = 5'b00100;
    wait_dead(0, 100, "flip_dead_reach");
    cnt = 1; flag_a = 1'b0;
    step();
    cnt += int'(bif.dead_l);
    bif.motor_state = 5'b00010;
    for (int i = 0; i < 80; i++) begin
      step();
      cnt += int'(bif.dead_l);
      if (bif.dir_l) flag_a = 1'b1;
    end
    check("flip_dead_len", 32'(cnt), 32'(DEADTIME));
    check("flip_dir_l", 32'(flag_a), 32'd0);
    check("flip_final", 32'(bif.duty_l), 32'(DUTY_FWD));

    // Randomized commands, overwrite pulses and resets against the model.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) < 8) ms = 5'b00001 << $urandom_range(0, 4);
      else                          ms = 5'($urandom_range(0, 31));
      bif.motor_state = ms;
      bif.overwrite   = ($urandom_range(0, 7) == 0);
      run($urandom_range(1, 60));
    end
    bif.overwrite = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/motor_driver.md
Name: motor_driver

Overview:
- Consumer end of the robot_fsm command interface: takes motor_state and overwrite and drives the two wheel H-bridges.
- Decodes each command into per-wheel direction and target duty.
- Ramps the duty toward the target and inserts dead time before any direction reversal.
- Generates one PWM output per wheel. Sits between robot_fsm and the GPIO motor pins.

Parameters:
- PWM_BITS, 8, width of the PWM counter and the duty values.
- DUTY_FWD, 192, target duty for FORWARD and REVERSE.
- DUTY_TURN, 96, target duty for LEFT and RIGHT spin turns.
- RAMP_DIV, 50000, clock cycles between ramp ticks.
- RAMP_STEP, 4, maximum duty change per ramp tick.
- DEADTIME, 25000, cycles held at zero duty before the direction output flips.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- motor_state  in  5  command from robot_fsm.
- overwrite  in  1  abort from robot_fsm; forces the motors off.
- pwm_l  out  1  left wheel PWM.
- pwm_r  out  1  right wheel PWM.
- dir_l  out  1  left direction; 0 = forward, 1 = reverse.
- dir_r  out  1  right direction; 0 = forward, 1 = reverse.
- enable  out  1  H-bridge enable; 0 while overwrite is high.
- busy  out  1  high while either wheel is ramping or in dead time.
- cmd_err  out  1  sticky illegal-command flag.

Behaviour:
- One clock domain (CLOCK_50). reset is synchronous and active-high.
- Reset values: all outputs 0; duty_cur=0 for both wheels; both channels in TRACK; PWM and ramp counters cleared.
- Command register:
  - motor_state and overwrite are registered once; decode acts on the registered copy (1-cycle input latency).
  - Decode table, as (dir_l, duty_l / dir_r, duty_r):
    - 00001 STOP: 0,0 / 0,0.
    - 00010 FORWARD: 0,DUTY_FWD / 0,DUTY_FWD.
    - 00100 LEFT: 1,DUTY_TURN / 0,DUTY_TURN.
    - 01000 RIGHT: 0,DUTY_TURN / 1,DUTY_TURN.
    - 10000 REVERSE: 1,DUTY_FWD / 1,DUTY_FWD.
  - Any other code decodes as STOP and sets cmd_err=1; it stays set until reset.
- Ramp tick: free-running counter pulses one cycle every RAMP_DIV cycles.
- Per-wheel channel FSM (two identical instances):
  - TRACK, target direction equals current direction: each tick, duty_cur moves toward the target by at most RAMP_STEP, clamped so it never overshoots. Saturating; no wrap at 0 or at 2^PWM_BITS-1.
  - TRACK, direction differs: each tick, ramp duty_cur toward 0. On reaching 0, go to DEAD and clear the dead counter.
  - DEAD: duty_cur held at 0. After DEADTIME cycles, dir takes the current target direction and the channel returns to TRACK.
    - A target change during DEAD does not shorten dead time; direction is re-evaluated at exit.
  - A target change in TRACK is re-targeted from the current duty_cur at the next tick; no restart.
- overwrite=1 (registered):
  - Next cycle: both duty_cur=0, pwm low, enable=0, both channels forced to DEAD. dir is held.
  - While overwrite stays high, the dead counter is held at 0.
  - On release: DEADTIME cycles, then ramp up from 0. enable returns to 1 on the cycle after release.
  - enable is 1 whenever reset is low and registered overwrite is low.
- PWM:
  - Shared free-running PWM_BITS counter; pwm_x = (cnt < duty_cur_x), registered.
  - duty 0 keeps pwm permanently low. Maximum duty 2^PWM_BITS-1 gives 255/256 high.
- busy = (either channel in DEAD) or (duty_cur != target on either wheel).
- Reset mid-ramp or mid-DEAD returns everything to reset values on the next edge.

Test Plan:
(Bench overrides: RAMP_DIV=4, RAMP_STEP=16, DUTY_FWD=128, DUTY_TURN=64, DEADTIME=8.)
1. Reset, then motor_state=00010 -> duty_l/duty_r climb 16 per tick and reach 128 after 8 ticks; dir both 0; busy drops at 128; pwm high exactly 128 of every 256 cycles.
2. At steady FORWARD, apply 00100 ->
   - Left ramps 128→0 in 8 ticks, holds 8 cycles in DEAD with dir_l=0, then dir_l=1 and ramps to 64.
   - Right ramps 128→64 in 4 ticks with dir_r=0 throughout.
3. At steady FORWARD, assert overwrite for 20 cycles -> next cycle pwm_l/pwm_r=0 and enable=0; after release, enable=1, 8 cycles of dead time, then ramp from 0 to 128.
4. motor_state=00011 -> both wheels ramp to 0; cmd_err=1 and stays 1 after a valid 00010 is applied; cleared only by reset.
5. Assert reset while a wheel is in DEAD -> next cycle all outputs 0 and channels in TRACK; a following 00010 ramps normally from 0.
6. FORWARD, then LEFT, then FORWARD again within 2 cycles of the left channel entering DEAD -> full 8-cycle dead time, dir_l stays 0, left ramps back to 128, no glitch on dir_l.
